// File: rtl/kl_pkg.sv
// Shared constants and types for the register file and its writeback interface.
package kl_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_AW = 3;
    localparam int unsigned NREGS  = 8;
    localparam int unsigned CNT_W  = 2;

    typedef logic [REG_AW-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;
    typedef logic [CNT_W-1:0]  pend_t;

    localparam pend_t PEND_MAX = '1;

    typedef struct packed {
        logic     write;
        reg_idx_t num;
        word_t    data;
    } wb_t;

    // Zero-cycle forwarding of an in-flight writeback onto a read port.
    function automatic word_t bypass(wb_t wb, reg_idx_t idx, word_t stored);
        return (wb.write && (wb.num == idx)) ? wb.data : stored;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register pending-write counters and RAW hazard detection for the decode read ports.
module regfile_scoreboard
    import kl_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     write_in,
    input  reg_idx_t writenum_in,
    input  reg_idx_t readnum_a_in,
    input  logic     read_a_en_in,
    input  reg_idx_t readnum_b_in,
    input  logic     read_b_en_in,
    input  logic     issue_in,
    input  logic     issue_write_in,
    input  reg_idx_t issue_num_in,
    input  logic     flush_in,
    output logic     hz_a_c,
    output logic     hz_b_c,
    output logic     stall_c
);

    pend_t            pend_q [NREGS];
    pend_t            pend_d [NREGS];
    logic [NREGS-1:0] inc_v;
    logic [NREGS-1:0] dec_v;
    logic             accept_c;

    // A source whose only outstanding writer is retiring this cycle is served by the bypass.
    always_comb begin
        hz_a_c   = read_a_en_in && (pend_q[readnum_a_in] != '0)
                   && !(write_in && (writenum_in == readnum_a_in) && (pend_q[readnum_a_in] == pend_t'(1)));
        hz_b_c   = read_b_en_in && (pend_q[readnum_b_in] != '0)
                   && !(write_in && (writenum_in == readnum_b_in) && (pend_q[readnum_b_in] == pend_t'(1)));
        stall_c  = (hz_a_c || hz_b_c) && !flush_in;
        accept_c = issue_in && !stall_c && !flush_in;
    end

    always_comb begin
        inc_v = '0;
        dec_v = '0;
        for (int unsigned r = 0; r < NREGS; r++) begin
            inc_v[r] = accept_c && issue_write_in && (issue_num_in == reg_idx_t'(r));
            dec_v[r] = write_in && (writenum_in == reg_idx_t'(r)) && (pend_q[r] != '0);
        end
    end

    // Flush wins over everything; a count at PEND_MAX saturates instead of wrapping.
    always_comb begin
        for (int unsigned r = 0; r < NREGS; r++) begin
            pend_d[r] = pend_q[r];
            if (flush_in) begin
                pend_d[r] = '0;
            end else if (inc_v[r] && !dec_v[r]) begin
                if (pend_q[r] != PEND_MAX) begin
                    pend_d[r] = pend_q[r] + pend_t'(1);
                end
            end else if (dec_v[r] && !inc_v[r]) begin
                pend_d[r] = pend_q[r] - pend_t'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                pend_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                pend_q[r] <= pend_d[r];
            end
        end
    end

    inc_at_max: assert property (@(posedge clk) disable iff (rst)
        !(accept_c && issue_write_in && (pend_q[issue_num_in] == PEND_MAX)));

endmodule

// File: rtl/regfile_wb_sink.sv
// Architectural register file fed by the stage-4 writeback, with bypassed decode read ports.
module regfile_wb_sink
    import kl_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     write_in,
    input  reg_idx_t writenum_in,
    input  word_t    writeback_data_in,
    input  reg_idx_t readnum_a_in,
    input  logic     read_a_en_in,
    input  reg_idx_t readnum_b_in,
    input  logic     read_b_en_in,
    output word_t    data_a_out,
    output word_t    data_b_out,
    input  logic     issue_in,
    input  logic     issue_write_in,
    input  reg_idx_t issue_num_in,
    input  logic     flush_in,
    output logic     stall_out
);

    word_t regs_q [NREGS];
    wb_t   wb;
    logic  hz_a;
    logic  hz_b;
    logic  stall_c;

    assign wb = '{write: write_in, num: writenum_in, data: writeback_data_in};

    // Writeback lands regardless of flush or stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                regs_q[r] <= '0;
            end
        end else if (write_in) begin
            regs_q[writenum_in] <= writeback_data_in;
        end
    end

    assign data_a_out = bypass(wb, readnum_a_in, regs_q[readnum_a_in]);
    assign data_b_out = bypass(wb, readnum_b_in, regs_q[readnum_b_in]);
    assign stall_out  = stall_c;

    regfile_scoreboard u_scoreboard (
        .clk            (clk),
        .rst            (rst),
        .write_in       (write_in),
        .writenum_in    (writenum_in),
        .readnum_a_in   (readnum_a_in),
        .read_a_en_in   (read_a_en_in),
        .readnum_b_in   (readnum_b_in),
        .read_b_en_in   (read_b_en_in),
        .issue_in       (issue_in),
        .issue_write_in (issue_write_in),
        .issue_num_in   (issue_num_in),
        .flush_in       (flush_in),
        .hz_a_c         (hz_a),
        .hz_b_c         (hz_b),
        .stall_c        (stall_c)
    );

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Scoreboard bench for regfile_wb_sink: directed scenarios plus a random back-to-back run.
module tb_regfile_wb_sink;

    logic        clk;
    logic        rst;
    logic        write_in;
    logic [2:0]  writenum_in;
    logic [15:0] writeback_data_in;
    logic [2:0]  readnum_a_in;
    logic        read_a_en_in;
    logic [2:0]  readnum_b_in;
    logic        read_b_en_in;
    logic [15:0] data_a_out;
    logic [15:0] data_b_out;
    logic        issue_in;
    logic        issue_write_in;
    logic [2:0]  issue_num_in;
    logic        flush_in;
    logic        stall_out;

    regfile_wb_sink dut (
        .clk               (clk),
        .rst               (rst),
        .write_in          (write_in),
        .writenum_in       (writenum_in),
        .writeback_data_in (writeback_data_in),
        .readnum_a_in      (readnum_a_in),
        .read_a_en_in      (read_a_en_in),
        .readnum_b_in      (readnum_b_in),
        .read_b_en_in      (read_b_en_in),
        .data_a_out        (data_a_out),
        .data_b_out        (data_b_out),
        .issue_in          (issue_in),
        .issue_write_in    (issue_write_in),
        .issue_num_in      (issue_num_in),
        .flush_in          (flush_in),
        .stall_out         (stall_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        w;
        logic [2:0]  wn;
        logic [15:0] wd;
        logic [2:0]  ra;
        logic        rae;
        logic [2:0]  rb;
        logic        rbe;
        logic        iss;
        logic        isw;
        logic [2:0]  isn;
        logic        fl;
        int          ks;   // hand-derived stall value, -1 when not annotated
    } stim_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        st;
        int          ks;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] m_regs [8];
    int          m_pend [8];
    stim_t       cur;
    logic        cur_stall;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic stim_t mk(logic w, logic [2:0] wn, logic [15:0] wd,
                                 logic [2:0] ra, logic rae, logic [2:0] rb, logic rbe,
                                 logic iss, logic isw, logic [2:0] isn, logic fl, int ks);
        stim_t s;
        s.w = w; s.wn = wn; s.wd = wd; s.ra = ra; s.rae = rae; s.rb = rb; s.rbe = rbe;
        s.iss = iss; s.isw = isw; s.isn = isn; s.fl = fl; s.ks = ks;
        return s;
    endfunction

    task automatic model_clear();
        for (int r = 0; r < 8; r++) begin
            m_regs[r] = 16'h0000;
            m_pend[r] = 0;
        end
    endtask

    // Drive one vector between edges and queue what the outputs must show.
    task automatic apply(input stim_t s);
        exp_t e;
        logic hza, hzb;
        @(negedge clk);
        write_in = s.w; writenum_in = s.wn; writeback_data_in = s.wd;
        readnum_a_in = s.ra; read_a_en_in = s.rae; readnum_b_in = s.rb; read_b_en_in = s.rbe;
        issue_in = s.iss; issue_write_in = s.isw; issue_num_in = s.isn; flush_in = s.fl;
        cur = s;
        e.a  = (s.w && s.wn == s.ra) ? s.wd : m_regs[s.ra];
        e.b  = (s.w && s.wn == s.rb) ? s.wd : m_regs[s.rb];
        hza  = s.rae && (m_pend[s.ra] != 0) && !(s.w && s.wn == s.ra && m_pend[s.ra] == 1);
        hzb  = s.rbe && (m_pend[s.rb] != 0) && !(s.w && s.wn == s.rb && m_pend[s.rb] == 1);
        e.st = (hza || hzb) && !s.fl;
        e.ks = s.ks;
        cur_stall = e.st;
        exp_q.push_back(e);
    endtask

    // Advance the model across the clock edge using the vector that was held there.
    task automatic tick();
        logic acc, inc, dec;
        @(posedge clk);
        acc = cur.iss && !cur_stall && !cur.fl;
        if (cur.w) m_regs[cur.wn] = cur.wd;
        for (int r = 0; r < 8; r++) begin
            inc = acc && cur.isw && (cur.isn == 3'(r));
            dec = cur.w && (cur.wn == 3'(r)) && (m_pend[r] != 0);
            if (cur.fl) m_pend[r] = 0;
            else if (inc && !dec) m_pend[r] = (m_pend[r] == 3) ? 3 : m_pend[r] + 1;
            else if (dec && !inc) m_pend[r] = m_pend[r] - 1;
        end
    endtask

    task automatic test_reset();
        stim_t v[$];
        exp_t  e;
        n_vec++;
        if ({data_a_out, data_b_out, stall_out} !== {16'h0000, 16'h0000, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state a=%h b=%h stall=%b expected 0000 0000 0", data_a_out, data_b_out, stall_out);
        end
        v.push_back(mk(1, 2, 16'h1234, 0, 0, 0, 0, 1, 1, 6, 0, 0));
        v.push_back(mk(0, 0, 16'h0000, 2, 1, 6, 1, 0, 0, 0, 0, 1));
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]);
            #1;
            e = exp_q.pop_front();
            n_vec++;
            if ({data_a_out, data_b_out, stall_out} !== {e.a, e.b, e.st}) begin
                n_err++;
                $display("FAIL reset[%0d] a=%h b=%h stall=%b expected a=%h b=%h stall=%b",
                         i, data_a_out, data_b_out, stall_out, e.a, e.b, e.st);
            end
            if (e.ks >= 0) begin
                n_vec++;
                if (stall_out !== e.ks[0]) begin
                    n_err++;
                    $display("FAIL reset_stall[%0d] stall=%b expected %0d", i, stall_out, e.ks);
                end
            end
            tick();
        end
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        n_vec++;
        if ({data_a_out, data_b_out, stall_out} !== {16'h0000, 16'h0000, 1'b0}) begin
            n_err++;
            $display("FAIL reset_midcycle a=%h b=%h stall=%b expected 0000 0000 0", data_a_out, data_b_out, stall_out);
        end
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_bypass();
        stim_t v[$];
        exp_t  e;
        v.push_back(mk(1, 5, 16'hBEEF, 5, 1, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 16'h0000, 5, 0, 5, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(1, 5, 16'h1111, 5, 1, 6, 1, 0, 0, 0, 0, 0));
        v.push_back(mk(1, 0, 16'hA5A5, 0, 1, 5, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]);
            #1;
            e = exp_q.pop_front();
            n_vec++;
            if ({data_a_out, data_b_out, stall_out} !== {e.a, e.b, e.st}) begin
                n_err++;
                $display("FAIL bypass[%0d] a=%h b=%h stall=%b expected a=%h b=%h stall=%b",
                         i, data_a_out, data_b_out, stall_out, e.a, e.b, e.st);
            end
            if (i == 0) begin
                n_vec++;
                if (data_a_out !== 16'hBEEF) begin
                    n_err++;
                    $display("FAIL bypass_same_cycle a=%h expected beef", data_a_out);
                end
            end
            tick();
        end
    endtask

    task automatic test_raw_stall();
        stim_t v[$];
        exp_t  e;
        v.push_back(mk(0, 0, 16'h0000, 1, 0, 0, 0, 1, 1, 3, 0, 0));
        v.push_back(mk(0, 0, 16'h0000, 3, 1, 0, 0, 1, 0, 0, 0, 1));
        v.push_back(mk(0, 0, 16'h0000, 3, 1, 0, 0, 1, 0, 0, 0, 1));
        v.push_back(mk(0, 0, 16'h0000, 0, 1, 3, 1, 0, 0, 0, 0, 1));
        v.push_back(mk(0, 0, 16'h0000, 0, 1, 3, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(1, 3, 16'h3333, 3, 1, 0, 0, 1, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 16'h0000, 3, 1, 3, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]);
            #1;
            e = exp_q.pop_front();
            n_vec++;
            if ({data_a_out, data_b_out, stall_out} !== {e.a, e.b, e.st}) begin
                n_err++;
                $display("FAIL raw_stall[%0d] a=%h b=%h stall=%b expected a=%h b=%h stall=%b",
                         i, data_a_out, data_b_out, stall_out, e.a, e.b, e.st);
            end
            if (e.ks >= 0) begin
                n_vec++;
                if (stall_out !== e.ks[0]) begin
                    n_err++;
                    $display("FAIL raw_stall_const[%0d] stall=%b expected %0d", i, stall_out, e.ks);
                end
            end
            tick();
        end
    endtask

    task automatic test_two_writers();
        stim_t v[$];
        exp_t  e;
        v.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 1, 1, 2, 0, 0));
        v.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 1, 1, 2, 0, 0));
        v.push_back(mk(1, 2, 16'h2222, 2, 1, 0, 0, 0, 0, 0, 0, 1));
        v.push_back(mk(1, 2, 16'h2223, 2, 1, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 16'h0000, 2, 1, 2, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]);
            #1;
            e = exp_q.pop_front();
            n_vec++;
            if ({data_a_out, data_b_out, stall_out} !== {e.a, e.b, e.st}) begin
                n_err++;
                $display("FAIL two_writers[%0d] a=%h b=%h stall=%b expected a=%h b=%h stall=%b",
                         i, data_a_out, data_b_out, stall_out, e.a, e.b, e.st);
            end
            if (e.ks >= 0) begin
                n_vec++;
                if (stall_out !== e.ks[0]) begin
                    n_err++;
                    $display("FAIL two_writers_const[%0d] stall=%b expected %0d", i, stall_out, e.ks);
                end
            end
            tick();
        end
    endtask

    task automatic test_inc_dec();
        stim_t v[$];
        exp_t  e;
        v.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 1, 1, 4, 0, 0));
        v.push_back(mk(1, 4, 16'h4444, 0, 0, 0, 0, 1, 1, 4, 0, 0));
        v.push_back(mk(0, 0, 16'h0000, 4, 1, 0, 0, 0, 0, 0, 0, 1));
        v.push_back(mk(1, 4, 16'h4445, 4, 1, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 16'h0000, 4, 1, 4, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]);
            #1;
            e = exp_q.pop_front();
            n_vec++;
            if ({data_a_out, data_b_out, stall_out} !== {e.a, e.b, e.st}) begin
                n_err++;
                $display("FAIL inc_dec[%0d] a=%h b=%h stall=%b expected a=%h b=%h stall=%b",
                         i, data_a_out, data_b_out, stall_out, e.a, e.b, e.st);
            end
            if (e.ks >= 0) begin
                n_vec++;
                if (stall_out !== e.ks[0]) begin
                    n_err++;
                    $display("FAIL inc_dec_const[%0d] stall=%b expected %0d", i, stall_out, e.ks);
                end
            end
            tick();
        end
    endtask

    task automatic test_flush();
        stim_t v[$];
        exp_t  e;
        v.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 1, 1, 1, 0, 0));
        v.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 1, 1, 1, 0, 0));
        v.push_back(mk(1, 1, 16'h1111, 1, 1, 1, 1, 1, 1, 7, 1, 0));
        v.push_back(mk(0, 0, 16'h0000, 1, 1, 7, 1, 0, 0, 0, 0, 0));
        v.push_back(mk(1, 1, 16'h1AAA, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 16'h0000, 0, 0, 0, 0, 1, 1, 1, 0, 0));
        v.push_back(mk(1, 1, 16'h1BBB, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        v.push_back(mk(0, 0, 16'h0000, 1, 1, 1, 1, 0, 0, 0, 0, 0));
        for (int i = 0; i < v.size(); i++) begin
            apply(v[i]);
            #1;
            e = exp_q.pop_front();
            n_vec++;
            if ({data_a_out, data_b_out, stall_out} !== {e.a, e.b, e.st}) begin
                n_err++;
                $display("FAIL flush[%0d] a=%h b=%h stall=%b expected a=%h b=%h stall=%b",
                         i, data_a_out, data_b_out, stall_out, e.a, e.b, e.st);
            end
            if (e.ks >= 0) begin
                n_vec++;
                if (stall_out !== e.ks[0]) begin
                    n_err++;
                    $display("FAIL flush_const[%0d] stall=%b expected %0d", i, stall_out, e.ks);
                end
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        stim_t s;
        exp_t  e;
        for (int i = 0; i < 300; i++) begin
            s = mk(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)), 16'($urandom),
                   3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   3'($urandom_range(0, 3)), 1'($urandom_range(0, 15) == 0), -1);
            if (s.isw && m_pend[s.isn] == 3) s.isw = 1'b0;
            apply(s);
            #1;
            e = exp_q.pop_front();
            n_vec++;
            if ({data_a_out, data_b_out, stall_out} !== {e.a, e.b, e.st}) begin
                n_err++;
                $display("FAIL back_to_back[%0d] a=%h b=%h stall=%b expected a=%h b=%h stall=%b",
                         i, data_a_out, data_b_out, stall_out, e.a, e.b, e.st);
            end
            tick();
        end
    endtask

    initial begin
        rst = 1'b1;
        write_in = 1'b0; writenum_in = '0; writeback_data_in = '0;
        readnum_a_in = 3'd0; read_a_en_in = 1'b1; readnum_b_in = 3'd7; read_b_en_in = 1'b1;
        issue_in = 1'b0; issue_write_in = 1'b0; issue_num_in = '0; flush_in = 1'b0;
        cur = mk(0, 0, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, -1);
        cur_stall = 1'b0;
        model_clear();
        #12 rst = 1'b0;
        #1;
        test_reset();
        test_bypass();
        test_raw_stall();
        test_two_writers();
        test_inc_dec();
        test_flush();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached after %0d vectors", n_vec);
        $fatal(1, "bench timeout");
    end

endmodule
